mix_jump_unit: RTL and testbench

MIX_JUMP_UNIT -- requirements
Module: mix_jump_unit

---
 rtl/mix_jump_unit_if.sv | 30 +++
 rtl/mix_jump_unit.sv | 80 ++++++++
 tb/tb_mix_jump_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mix_jump_unit_if.sv
// mix_jump_unit_if: request/result bundle between a MIX sequencer and the jump unit
interface mix_jump_unit_if #(
  parameter int MAG_W  = 30,
  parameter int ADDR_W = 12,
  parameter int NREG   = 8
);
  logic                        start;
  logic [5:0]                  opcode;
  logic [3:0]                  field;
  logic [ADDR_W-1:0]           addr;
  logic [ADDR_W-1:0]           pc_next;
  logic [(MAG_W+1)*NREG-1:0]   regs;
  logic [1:0]                  cmp;
  logic                        ovf_set;
  logic                        busy;
  logic                        done;
  logic                        taken;
  logic [ADDR_W-1:0]           target;
  logic                        illegal;
  logic [ADDR_W-1:0]           j_reg;
  logic                        ovf;
  modport master (
    output start, opcode, field, addr, pc_next, regs, cmp, ovf_set,
    input  busy, done, taken, target, illegal, j_reg, ovf
  );
  modport slave (
    input  start, opcode, field, addr, pc_next, regs, cmp, ovf_set,
    output busy, done, taken, target, illegal, j_reg, ovf
  );
endinterface

// File: rtl/mix_jump_unit.sv
// mix_jump_unit: evaluates MIX conditional/register jumps and maintains J and overflow
module mix_jump_unit #(
  parameter int MAG_W  = 30,
  parameter int ADDR_W = 12,
  parameter int NREG   = 8
) (
  input logic            clk,
  input logic            rst,
  mix_jump_unit_if.slave bus
);
  localparam int W = MAG_W + 1;
  typedef enum logic {IDLE, EVAL} state_t;
  state_t            state, nxt;
  logic [5:0]        c_op;
  logic [3:0]        c_f;
  logic [ADDR_W-1:0] c_addr, c_pc;
  logic [W-1:0]      c_reg, sel;
  logic [1:0]        c_cmp;
  logic              c_ovf, accept, ev, is_jmp, is_reg, z, neg, lt, gt, eq, tk, ill, ovf_clr;
  logic [15:0]       rc, jc;
  assign accept  = state == IDLE && bus.start;
  assign ev      = state == EVAL;
  assign bus.busy = ev;
  assign is_jmp  = c_op == 6'd39;
  assign is_reg  = c_op >= 6'd40 && 32'(c_op) < 32'(40 + NREG);
  assign z       = c_reg[MAG_W-1:0] == '0;
  assign neg     = c_reg[MAG_W] & ~z;
  assign lt      = c_cmp == 2'd1;
  assign gt      = c_cmp == 2'd2;
  assign eq      = ~lt & ~gt;
  assign rc      = {8'd0, c_reg[0], ~c_reg[0], z | c_reg[MAG_W], ~z, ~neg, ~z & ~c_reg[MAG_W], z, neg};
  assign jc      = {6'd0, ~gt, ~eq, ~lt, gt, eq, lt, ~c_ovf, c_ovf, 2'b11};
  assign ill     = is_jmp ? c_f > 4'd9 : is_reg ? c_f[3] : 1'b1;
  assign tk      = is_jmp ? jc[c_f] : is_reg & rc[c_f];
  assign ovf_clr = ev & is_jmp & (c_f == 4'd2 || c_f == 4'd3);
  // pick the register addressed by opcode-40; out-of-range opcodes capture zero
  always_comb begin
    sel = '0;
    for (int k = 0; k < NREG; k++)
      if (bus.opcode == 6'(40 + k)) sel = bus.regs[k*W +: W];
  end
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  // a request lasts exactly one evaluation cycle
  always_comb begin
    nxt = IDLE;
    nxt = (state == IDLE && bus.start) ? EVAL : IDLE;
  end
  // snapshot operands at acceptance so later input changes cannot disturb the result
  always_ff @(posedge clk)
    if (accept) begin
      c_op   <= bus.opcode;
      c_f    <= bus.field;
      c_addr <= bus.addr;
      c_pc   <= bus.pc_next;
      c_reg  <= sel;
      c_cmp  <= bus.cmp;
      c_ovf  <= bus.ovf;
    end
  // result registers, J update (JSJ excluded) and overflow toggle with set beating clear
  always_ff @(posedge clk)
    if (rst) begin
      bus.done    <= 1'b0;
      bus.taken   <= 1'b0;
      bus.target  <= '0;
      bus.illegal <= 1'b0;
      bus.j_reg   <= '0;
      bus.ovf     <= 1'b0;
    end else begin
      bus.done <= ev;
      if (ev) begin
        bus.taken   <= tk;
        bus.target  <= tk ? c_addr : '0;
        bus.illegal <= ill;
      end
      if (ev && tk && !(is_jmp && c_f == 4'd1)) bus.j_reg <= c_pc;
      bus.ovf <= bus.ovf_set | (bus.ovf & ~ovf_clr);
    end
endmodule

// File: tb/tb_mix_jump_unit.sv
// tb_mix_jump_unit: directed checks of the MIX jump unit at default and reduced widths
module tb_mix_jump_unit;
  logic clk, rst;
  int tests = 0, fails = 0;
  mix_jump_unit_if #(.MAG_W(30), .ADDR_W(12), .NREG(8)) b1 ();
  mix_jump_unit_if #(.MAG_W(14), .ADDR_W(12), .NREG(2)) b2 ();
  mix_jump_unit #(.MAG_W(30), .ADDR_W(12), .NREG(8)) u1 (.clk(clk), .rst(rst), .bus(b1));
  mix_jump_unit #(.MAG_W(14), .ADDR_W(12), .NREG(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic go(input logic [5:0] op, input logic [3:0] f, input logic [11:0] a, input logic [11:0] pc);
    b1.opcode  = op;
    b1.field   = f;
    b1.addr    = a;
    b1.pc_next = pc;
    b1.start   = 1'b1;
    @(negedge clk);
    b1.start   = 1'b0;
  endtask
  task automatic fin(input string tag, input logic tk, input logic [11:0] tgt, input logic il, input logic [11:0] jr, input logic ov);
    @(negedge clk);
    chk({tag, ".done"}, b1.done, 1);
    chk({tag, ".taken"}, b1.taken, tk);
    chk({tag, ".target"}, b1.target, tgt);
    chk({tag, ".illegal"}, b1.illegal, il);
    chk({tag, ".j_reg"}, b1.j_reg, jr);
    chk({tag, ".ovf"}, b1.ovf, ov);
  endtask
  task automatic pulse_ovf;
    b1.ovf_set = 1'b1;
    @(negedge clk);
    b1.ovf_set = 1'b0;
    chk("ovf_set", b1.ovf, 1);
  endtask
  initial begin
    rst = 1'b1;
    b1.start = 0; b1.opcode = 0; b1.field = 0; b1.addr = 0; b1.pc_next = 0; b1.cmp = 0; b1.ovf_set = 0;
    b1.regs = '0;
    b1.regs[30:0]  = {1'b1, 30'd5};
    b1.regs[61:31] = {1'b1, 30'd0};
    b2.start = 0; b2.opcode = 0; b2.field = 0; b2.addr = 0; b2.pc_next = 0; b2.cmp = 0; b2.ovf_set = 0;
    b2.regs = {15'd3, 15'd0};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst.busy", b1.busy, 0);
    chk("rst.done", b1.done, 0);
    chk("rst.taken", b1.taken, 0);
    chk("rst.target", b1.target, 0);
    chk("rst.illegal", b1.illegal, 0);
    chk("rst.j_reg", b1.j_reg, 0);
    chk("rst.ovf", b1.ovf, 0);
    go(40, 0, 100, 7);
    chk("jan.busy", b1.busy, 1);
    chk("jan.done_early", b1.done, 0);
    fin("jan", 1, 100, 0, 7, 0);
    go(39, 1, 50, 99);  fin("jsj", 1, 50, 0, 7, 0);
    go(41, 0, 200, 9);  fin("j1n_mz", 0, 0, 0, 7, 0);
    go(41, 1, 200, 9);  fin("j1z_mz", 1, 200, 0, 9, 0);
    pulse_ovf();
    go(39, 2, 60, 11);  fin("jov1", 1, 60, 0, 11, 0);
    go(39, 2, 61, 12);  fin("jov2", 0, 0, 0, 11, 0);
    pulse_ovf();
    go(39, 3, 62, 13);
    b1.ovf_set = 1'b1;
    fin("jnov_setwin", 0, 0, 0, 11, 1);
    b1.ovf_set = 1'b0;
    go(39, 3, 63, 14);  fin("jnov_clr", 0, 0, 0, 11, 0);
    b1.cmp = 2'd1;
    go(39, 4, 70, 15);  fin("jl", 1, 70, 0, 15, 0);
    go(39, 7, 71, 16);  fin("jge", 0, 0, 0, 15, 0);
    b1.cmp = 2'd3;
    go(39, 5, 72, 17);  fin("je3", 1, 72, 0, 17, 0);
    go(39, 8, 73, 18);  fin("jne3", 0, 0, 0, 17, 0);
    b1.cmp = 2'd2;
    go(39, 6, 74, 19);  fin("jg", 1, 74, 0, 19, 0);
    go(39, 9, 75, 20);  fin("jle", 0, 0, 0, 19, 0);
    go(40, 2, 80, 21);  fin("jap", 0, 0, 0, 19, 0);
    go(41, 3, 81, 22);  fin("j1nn_mz", 1, 81, 0, 22, 0);
    go(40, 7, 82, 23);  fin("jao", 1, 82, 0, 23, 0);
    go(40, 6, 83, 24);  fin("jae", 0, 0, 0, 23, 0);
    pulse_ovf();
    go(39, 12, 90, 25); fin("ill_f12", 0, 0, 1, 23, 1);
    go(20, 0, 91, 26);  fin("ill_op20", 0, 0, 1, 23, 1);
    go(48, 0, 92, 27);  fin("ill_op48", 0, 0, 1, 23, 1);
    go(40, 9, 93, 28);  fin("ill_rf9", 0, 0, 1, 23, 1);
    go(47, 1, 94, 29);  fin("jxz", 1, 94, 0, 29, 1);
    go(40, 0, 300, 31);
    b1.regs[30] = 1'b0;
    b1.addr     = 12'd5;
    b1.opcode   = 6'd39;
    b1.start    = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    chk("capt.done", b1.done, 1);
    chk("capt.taken", b1.taken, 1);
    chk("capt.target", b1.target, 300);
    @(negedge clk);
    chk("ignored.done", b1.done, 0);
    chk("ignored.busy", b1.busy, 0);
    b1.regs[30] = 1'b1;
    go(39, 0, 500, 50);
    rst = 1'b1; b1.start = 1'b1; b1.ovf_set = 1'b1;
    @(negedge clk);
    chk("midrst.done", b1.done, 0);
    chk("midrst.busy", b1.busy, 0);
    chk("midrst.taken", b1.taken, 0);
    chk("midrst.target", b1.target, 0);
    chk("midrst.illegal", b1.illegal, 0);
    chk("midrst.j_reg", b1.j_reg, 0);
    chk("midrst.ovf", b1.ovf, 0);
    rst = 1'b0; b1.start = 1'b0; b1.ovf_set = 1'b0;
    @(negedge clk);
    chk("postrst.done", b1.done, 0);
    b2.opcode = 41; b2.field = 7; b2.addr = 5; b2.pc_next = 3; b2.start = 1'b1;
    @(negedge clk);
    b2.start = 1'b0;
    @(negedge clk);
    chk("small.done", b2.done, 1);
    chk("small.taken", b2.taken, 1);
    chk("small.target", b2.target, 5);
    chk("small.j_reg", b2.j_reg, 3);
    b2.opcode = 42; b2.field = 0; b2.start = 1'b1;
    @(negedge clk);
    b2.start = 1'b0;
    @(negedge clk);
    chk("small_ill.illegal", b2.illegal, 1);
    chk("small_ill.taken", b2.taken, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
